shub_switch: RTL and testbench

SHUB_SWITCH -- requirements
Module: shub_switch

---
 rtl/shub_pkg.sv | 21 ++
 rtl/shub_fifo.sv | 72 +++++++
 rtl/shub_switch.sv | 147 ++++++++++++++
 tb/tb_shub_switch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shub_pkg.sv
// Shared constants and helpers for the shub cluster switch.
//   FLIT_W_DEF   : default flit width
//   DEST_LSB_DEF : default LSB of the destination field inside a flit
//   STAT_W       : width of each per-output delivered-flit counter
//   clog2()      : ceiling log2, usable in parameter expressions
package shub_pkg;

    localparam int FLIT_W_DEF   = 20;
    localparam int DEST_LSB_DEF = 16;
    localparam int STAT_W       = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/shub_fifo.sv
// Synchronous per-input flit buffer with registered empty and ready flags.
//   clk, rst  : clock (rising edge), asynchronous active-low reset
//   push      : write request; only taken while ready is high
//   wdata     : flit to write
//   pop       : read request; only taken while empty is low
//   rdata     : head flit (valid while empty is low)
//   empty     : registered "no flit stored"
//   ready     : registered "not full"; low during reset and on the first
//               edge into reset, rises on the first edge after release
module shub_fifo
    import shub_pkg::*;
#(
    parameter int WIDTH = FLIT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign do_push = push && ready_q;
    assign do_pop  = pop && !empty_q;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q[AW-1:0]];
    assign empty = empty_q;
    assign ready = ready_q;

endmodule

// File: rtl/shub_switch.sv
// NUM_PORTS x NUM_PORTS cluster switch: one FIFO per input, one round-robin
// arbiter and one output register per output.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   in_data    : flits from clusters, port p at [p*FLIT_W +: FLIT_W]
//   in_valid   : per-port input valid
//   in_co      : per-port "switch can accept" (registered FIFO not-full)
//   out_data   : flits to clusters, port q at [q*FLIT_W +: FLIT_W]
//   out_valid  : per-port output valid
//   out_ci     : per-port "cluster can accept"
//   stat_count : per-output delivered-flit counters, 16 bits each
// Optional feature macro: SHUB_STATS_EN enables the saturating counters;
// without it stat_count is tied to zero.
module shub_switch
    import shub_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int FLIT_W     = FLIT_W_DEF,
    parameter int DEST_LSB   = DEST_LSB_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*FLIT_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_co,
    output logic [NUM_PORTS*FLIT_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ci,
    output logic [NUM_PORTS*STAT_W-1:0] stat_count
);

    localparam int PW = clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] head_empty;
    logic [NUM_PORTS-1:0] pop;
    logic [FLIT_W-1:0]    head_data [NUM_PORTS];

    logic [PW-1:0]        rr_q [NUM_PORTS];
    logic [PW-1:0]        rr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]    out_data_q [NUM_PORTS];
    logic [FLIT_W-1:0]    out_data_d [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        shub_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[p]),
            .wdata (in_data[p*FLIT_W +: FLIT_W]),
            .pop   (pop[p]),
            .rdata (head_data[p]),
            .empty (head_empty[p]),
            .ready (in_co[p])
        );
    end

    // Each head targets exactly one output, so a FIFO can be granted by at
    // most one arbiter per cycle and all outputs arbitrate in parallel.
    always_comb begin
        logic          found;
        logic          load;
        logic [PW-1:0] idx;
        pop         = '0;
        out_valid_d = out_valid_q;
        found       = 1'b0;
        load        = 1'b0;
        idx         = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            rr_d[q]       = rr_q[q];
            out_data_d[q] = out_data_q[q];
            load          = !out_valid_q[q] || out_ci[q];
            found         = 1'b0;
            if (load) begin
                out_valid_d[q] = 1'b0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    // NUM_PORTS is a power of two, so PW-bit wrap is mod N.
                    idx = rr_q[q] + PW'(i);
                    if (!found && !head_empty[idx] &&
                        (head_data[idx][DEST_LSB +: PW] == PW'(q))) begin
                        found          = 1'b1;
                        pop[idx]       = 1'b1;
                        out_valid_d[q] = 1'b1;
                        out_data_d[q]  = head_data[idx];
                        rr_d[q]        = idx + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                rr_q[q]       <= '0;
                out_data_q[q] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int q = 0; q < NUM_PORTS; q++) begin
                rr_q[q]       <= rr_d[q];
                out_data_q[q] <= out_data_d[q];
            end
        end
    end

    assign out_valid = out_valid_q;
    for (genvar q = 0; q < NUM_PORTS; q++) begin : g_out
        assign out_data[q*FLIT_W +: FLIT_W] = out_data_q[q];
    end

`ifdef SHUB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_PORTS];
    logic [STAT_W-1:0] stat_d [NUM_PORTS];

    always_comb begin
        for (int q = 0; q < NUM_PORTS; q++) begin
            stat_d[q] = stat_q[q];
            if (out_valid_q[q] && out_ci[q] && (stat_q[q] != '1)) begin
                stat_d[q] = stat_q[q] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                stat_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                stat_q[q] <= stat_d[q];
            end
        end
    end

    for (genvar q = 0; q < NUM_PORTS; q++) begin : g_stat
        assign stat_count[q*STAT_W +: STAT_W] = stat_q[q];
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_shub_switch.sv
// Directed self-checking bench for shub_switch (default parameters).
module tb_shub_switch;

    localparam int N  = 4;
    localparam int FW = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*FW-1:0] in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_co;
    logic [N*FW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ci = '1;
    logic [N*16-1:0] stat_count;

    int tests = 0;
    int fails = 0;

    shub_switch dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_co      (in_co),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ci     (out_ci),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] odat(input int q);
        return out_data[q*FW +: FW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = '0; in_data = '0; out_ci = '1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int k, rx, seen;
        logic sent;

        // Reset behaviour
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_in_co", 32'(in_co), 32'h0);
            check("rst_stat", 32'(stat_count[31:0] | stat_count[63:32]), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("in_co_after_release", 32'(in_co), 32'hF);

        // Single flit, port 0 -> output 2
        in_data[0*FW +: FW] = 20'h2_1234; in_valid = 4'b0001;
        @(negedge clk);
        in_valid = '0;
        check("single_not_yet", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'h4);
        check("single_data", 32'(odat(2)), 32'h2_1234);
        @(negedge clk);
        check("single_drained", 32'(out_valid), 32'h0);

        // Parallel grants plus loopback: p0->2, p1->3, p3->3
        in_data[0*FW +: FW] = 20'h2_0AAA;
        in_data[1*FW +: FW] = 20'h3_0BBB;
        in_data[3*FW +: FW] = 20'h3_0CCC;
        in_valid = 4'b1011;
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        check("par_valid", 32'(out_valid), 32'hC);
        check("par_out2", 32'(odat(2)), 32'h2_0AAA);
        check("par_out3_first", 32'(odat(3)), 32'h3_0BBB);
        @(negedge clk);
        check("loop_valid", 32'(out_valid), 32'h8);
        check("loop_out3", 32'(odat(3)), 32'h3_0CCC);
        @(negedge clk);
        check("par_drained", 32'(out_valid), 32'h0);
        check("stat_tied_or_count", 32'(stat_count[2*16 +: 16]),
`ifdef SHUB_STATS_EN
              32'd2
`else
              32'd0
`endif
        );

        // Contention: all ports to output 1
        do_reset();
        for (int p = 0; p < N; p++) in_data[p*FW +: FW] = 20'h1_0000 + FW'(p);
        in_valid = 4'hF;
        seen = 0;
        for (int c = 0; c < 10 && !out_valid[1]; c++) @(negedge clk);
        check("cont_start", 32'(out_valid[1]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("cont_valid", 32'(out_valid), 32'h2);
            check("cont_src", 32'(odat(1)), 32'h1_0000 + 32'(i % 4));
            @(negedge clk);
        end
        in_valid = '0;

        // Backpressure: port 2 -> output 3 with output 3 stalled
        do_reset();
        out_ci = 4'b0111;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            sent = (k < 6) && in_co[2];
            in_valid = sent ? 4'b0100 : 4'b0000;
            in_data[2*FW +: FW] = 20'h3_2000 + FW'(k);
            @(posedge clk);
            if (sent) k++;
            @(negedge clk);
            if (c >= 1) begin
                check("bp_hold_valid", 32'(out_valid[3]), 32'h1);
                check("bp_hold_data", 32'(odat(3)), 32'h3_2000);
            end
        end
        check("bp_accepted", 32'(k), 32'd5);
        check("bp_in_co_low", 32'(in_co[2]), 32'h0);
        out_ci = 4'hF;
        rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            sent = (k < 6) && in_co[2];
            in_valid = sent ? 4'b0100 : 4'b0000;
            in_data[2*FW +: FW] = 20'h3_2000 + FW'(k);
            if (out_valid[3] && out_ci[3]) begin
                check("bp_order", 32'(odat(3)), 32'h3_2000 + 32'(rx));
                rx++;
            end
            @(posedge clk);
            if (sent) k++;
            @(negedge clk);
        end
        in_valid = '0;
        check("bp_all_arrived", 32'(rx), 32'd6);
        check("bp_all_sent", 32'(k), 32'd6);
        check("bp_stat3", 32'(stat_count[3*16 +: 16]),
`ifdef SHUB_STATS_EN
              32'd6
`else
              32'd0
`endif
        );

        // Mid-traffic reset with flits buffered behind a stalled output
        out_ci = 4'h0;
        for (int j = 0; j < 3; j++) begin
            in_data[0*FW +: FW] = 20'h1_0100 + FW'(j);
            in_valid = 4'b0001;
            @(negedge clk);
        end
        in_valid = '0;
        @(negedge clk);
        check("mid_pre_valid", 32'(out_valid), 32'h2);
        #2 rst = 1'b0;
        #1;
        check("mid_async_valid", 32'(out_valid), 32'h0);
        check("mid_async_in_co", 32'(in_co), 32'h0);
        check("mid_async_stat", 32'(stat_count[31:0] | stat_count[63:32]), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1; out_ci = 4'hF;
        @(negedge clk);
        check("mid_in_co", 32'(in_co), 32'hF);
        for (int c = 0; c < 6; c++) begin
            check("mid_no_stale", 32'(out_valid), 32'h0);
            @(negedge clk);
        end

`ifdef SHUB_STATS_EN
        // Saturation of output 0's counter
        in_data[1*FW +: FW] = 20'h0_0055;
        in_valid = 4'b0010;
        repeat (70010) @(negedge clk);
        check("stat0_sat", 32'(stat_count[0 +: 16]), 32'hFFFF);
        repeat (5) @(negedge clk);
        in_valid = '0;
        check("stat0_stays", 32'(stat_count[0 +: 16]), 32'hFFFF);
        check("stat_others", 32'(stat_count[16 +: 48]), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
